e_result_streamer: RTL and testbench
====================================

# e_result_streamer

Reader-side companion to `e_calc`. On each rising edge of `e_calc`'s `done`, it snapshots the multi-word fixed-point result and streams it out as lowercase ASCII hex characters over a valid/ready byte interface, most-significant word first. It sits between `e_calc` and a byte sink such as a UART transmitter or a simulation monitor, so the computed value of e can be read without probing internal arrays.

## Interface
- `WORDS`, default 32: number of 16-bit result words; must be ≥ 1.
- `clk`  in  1: single clock; all logic on the rising edge.
- `rst_n`  in  1: asynchronous, active-low reset.
- `done`  in  1: completion level from `e_calc`; only its rising edge is acted on.
- `result`  in  16 × [0:WORDS-1]: result array from `e_calc`; `result[WORDS-1]` is the most significant word.
- `busy`  out  1: high from the capture edge until the last character is accepted.
- `tx_valid`  out  1: a character is presented on `tx_data`.
- `tx_data`  out  8: ASCII character.
- `tx_ready`  in  1: sink accepts the character when `tx_valid && tx_ready` at a clock edge.
- `stream_done`  out  1: one-cycle pulse after the final character is accepted.

## Operation
- States: IDLE → SEND → (EOL, only with the macro) → FIN → IDLE.
- IDLE: `done_q` registers `done` every cycle. A rise is `done && !done_q`. On a rise: copy all of `result` into a snapshot, set `word_idx = WORDS-1` and `nib_idx = 3`, then go to SEND.
- SEND: `tx_data` is the ASCII code of `snapshot[word_idx][4*nib_idx +: 4]`. Nibbles 0–9 map to 0x30–0x39; nibbles a–f map to 0x61–0x66. On each accepted character, decrement `nib_idx`. When `nib_idx` wraps from 0 to 3, decrement `word_idx`. Acceptance of the character at `word_idx = 0`, `nib_idx = 0` ends SEND.
- FIN: lasts one cycle. `stream_done = 1`, `busy = 0`, then IDLE.
- Total characters per capture: 4·WORDS, plus 2 with the macro.
- The snapshot is immune to changes on `result` during streaming.
- A `done` rise while not in IDLE is ignored and is not queued. `done_q` keeps tracking, so a `done` held high does not retrigger on return to IDLE.
- Reset values: `busy = 0`, `tx_valid = 0`, `tx_data = 8'h00`, `stream_done = 0`, state IDLE, `done_q = 1`. With `done_q = 1`, a `done` already high at reset release does not trigger.
- Reset mid-stream aborts immediately. The partial stream is not resumed. A new `done` rise is required.

## Timing
- Capture edge k (the rise is sampled at edge k): `busy` and `tx_valid` are high after edge k. The first character is valid in cycle k+1.
- `tx_valid`, `tx_data` and `busy` are registered outputs.
- While `tx_valid && !tx_ready`, `tx_data` holds stable and `tx_valid` stays high. `tx_valid` never drops without acceptance.
- The next character is presented the cycle after acceptance, with no bubble. With `tx_ready` tied high, one character is sent per cycle.
- With `tx_ready` held high from cycle k+1, the last character is accepted at edge k+4·WORDS (+2 with the macro). FIN and `stream_done` occupy the following cycle. `busy` falls with FIN.
- `tx_valid` never depends combinationally on `tx_ready`.

## Configuration
- `E_STREAM_EOL_EN` defined: after the last hex character, the EOL state sends 0x0D then 0x0A under the same handshake, then goes to FIN.
- Without the macro: the EOL state does not exist, and SEND goes directly to FIN.

## Structure
- Package `e_stream_pkg`:
  - state enum `stream_state_t`
  - constants `ASCII_CR = 8'h0D`, `ASCII_LF = 8'h0A`
  - function `hex_ascii(logic [3:0]) → logic [7:0]`
- One sub-module `nibble_ascii`, a registered nibble-to-ASCII mapper. The top level holds the FSM, the counters and the snapshot.

## Test plan
- `WORDS = 2`, `result[1] = 16'h2b7e`, `result[0] = 16'h1516`, `tx_ready = 1`, pulse `done` → characters "2b7e1516" on consecutive cycles. `stream_done` pulses once after the last character. With the macro, the stream also ends 0x0D, 0x0A.
- Same stimulus with `tx_ready` toggling 1-0-0-1 → identical character sequence. `tx_data` stays stable while stalled, and no character is duplicated or dropped.
- Change `result` to all `ffff` mid-stream → output still matches the snapshot.
- Second `done` rise while busy → ignored. Exactly one stream, and no stream afterwards even though `done` stays high.
- Hold `done = 1` through reset release → no stream. A later 0→1 on `done` → stream starts.
- Assert `rst_n = 0` at the third character → `tx_valid`, `busy` and `stream_done` go to 0 immediately. After release, no output until the next `done` rise.

Source files
------------

// File: rtl/e_stream_pkg.sv
// Shared types, constants and the nibble-to-ASCII helper for e_result_streamer.
// Define E_STREAM_EOL_EN to add the CR/LF terminator state.
package e_stream_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEND = 2'd1,
`ifdef E_STREAM_EOL_EN
    ST_EOL  = 2'd2,
`endif
    ST_FIN  = 2'd3
  } stream_state_t;

  localparam logic [7:0] ASCII_CR = 8'h0D;
  localparam logic [7:0] ASCII_LF = 8'h0A;

  // Lowercase hex digit: 0-9 -> '0'..'9', a-f -> 'a'..'f'.
  function automatic logic [7:0] hex_ascii(input logic [3:0] nib);
    if (nib < 4'd10) return 8'h30 + {4'h0, nib};
    else             return 8'h57 + {4'h0, nib};
  endfunction

endpackage

// File: rtl/e_result_streamer_nibble_ascii.sv
// Registered character source: loads either a hex digit or a raw byte on demand.
module nibble_ascii
  import e_stream_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       load,
  input  logic       raw_sel,
  input  logic [7:0] raw,
  input  logic [3:0] nibble,
  output logic [7:0] ascii
);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of process ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ascii <= 8'h00;
    end else if (load) begin
      ascii <= raw_sel ? raw : hex_ascii(nibble);
    end
  end

endmodule

// File: rtl/e_result_streamer.sv
// Snapshots the e_calc result on a rising done and streams it as lowercase hex,
// MS word first, over valid/ready. Optional E_STREAM_EOL_EN appends CR LF.
module e_result_streamer
  import e_stream_pkg::*;
#(
  parameter int WORDS = 32
)(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        done,
  input  logic [15:0] result [0:WORDS-1],
  output logic        busy,
  output logic        tx_valid,
  output logic [7:0]  tx_data,
  input  logic        tx_ready,
  output logic        stream_done
);

  localparam int WW = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam logic [WW-1:0] LAST_WORD = WW'(WORDS - 1);

  stream_state_t state, state_d;
  logic          done_q;
  logic [15:0]   snapshot [0:WORDS-1];
  logic [WW-1:0] word_idx, word_d, nxt_word;
  logic [1:0]    nib_idx, nib_d, nxt_nib;
  logic          busy_d, tx_valid_d;
  logic          capture, accept, last_char;
  logic          chr_load, chr_raw_sel;
  logic [7:0]    chr_raw;
  logic [3:0]    chr_nib;
  logic [15:0]   sel_word;
`ifdef E_STREAM_EOL_EN
  logic          eol_lf, eol_lf_d;
`endif

  assign accept      = tx_valid & tx_ready;
  assign last_char   = (word_idx == '0) && (nib_idx == 2'd0);
  assign nxt_nib     = nib_idx - 2'd1;
  assign nxt_word    = (nib_idx == 2'd0) ? word_idx - 1'b1 : word_idx;
  assign sel_word    = snapshot[nxt_word];
  assign stream_done = (state == ST_FIN);

  // The first character comes straight from result, since the snapshot
  // is being written on that same edge; later ones read the snapshot.
  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves
    // one unassigned, which would otherwise infer a latch.
    state_d     = state;
    busy_d      = busy;
    tx_valid_d  = tx_valid;
    word_d      = word_idx;
    nib_d       = nib_idx;
    capture     = 1'b0;
    chr_load    = 1'b0;
    chr_raw_sel = 1'b0;
    chr_raw     = ASCII_CR;
    chr_nib     = result[WORDS-1][15:12];
`ifdef E_STREAM_EOL_EN
    eol_lf_d    = eol_lf;
`endif
    case (state)
      ST_IDLE: begin
        if (done && !done_q) begin
          capture    = 1'b1;
          chr_load   = 1'b1;
          state_d    = ST_SEND;
          busy_d     = 1'b1;
          tx_valid_d = 1'b1;
          word_d     = LAST_WORD;
          nib_d      = 2'd3;
        end
      end
      ST_SEND: begin
        if (accept) begin
          if (last_char) begin
`ifdef E_STREAM_EOL_EN
            state_d     = ST_EOL;
            chr_load    = 1'b1;
            chr_raw_sel = 1'b1;
            chr_raw     = ASCII_CR;
            eol_lf_d    = 1'b0;
`else
            state_d    = ST_FIN;
            busy_d     = 1'b0;
            tx_valid_d = 1'b0;
`endif
          end else begin
            word_d   = nxt_word;
            nib_d    = nxt_nib;
            chr_load = 1'b1;
            chr_nib  = sel_word[{nxt_nib, 2'b00} +: 4];
          end
        end
      end
`ifdef E_STREAM_EOL_EN
      ST_EOL: begin
        if (accept) begin
          if (!eol_lf) begin
            chr_load    = 1'b1;
            chr_raw_sel = 1'b1;
            chr_raw     = ASCII_LF;
            eol_lf_d    = 1'b1;
          end else begin
            state_d    = ST_FIN;
            busy_d     = 1'b0;
            tx_valid_d = 1'b0;
          end
        end
      end
`endif
      ST_FIN:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      done_q   <= 1'b1;
      busy     <= 1'b0;
      tx_valid <= 1'b0;
      word_idx <= '0;
      nib_idx  <= 2'd0;
`ifdef E_STREAM_EOL_EN
      eol_lf   <= 1'b0;
`endif
    end else begin
      state    <= state_d;
      done_q   <= done;
      busy     <= busy_d;
      tx_valid <= tx_valid_d;
      word_idx <= word_d;
      nib_idx  <= nib_d;
`ifdef E_STREAM_EOL_EN
      eol_lf   <= eol_lf_d;
`endif
    end
  end

  // NOTE: the snapshot is plain storage qualified by capture, so it takes no
  // reset; nothing reads it before the first capture writes it.
  always_ff @(posedge clk) begin
    if (capture) snapshot <= result;
  end

  nibble_ascii u_nibble_ascii (
    .clk     (clk),
    .rst_n   (rst_n),
    .load    (chr_load),
    .raw_sel (chr_raw_sel),
    .raw     (chr_raw),
    .nibble  (chr_nib),
    .ascii   (tx_data)
  );

endmodule

// File: tb/tb_e_result_streamer.sv
// Scoreboard bench for e_result_streamer (WORDS = 2); define E_STREAM_EOL_EN
// for both bench and RTL to cover the CR/LF build.
module tb_e_result_streamer;

  localparam int WORDS = 2;
`ifdef E_STREAM_EOL_EN
  localparam int N_CHARS = 4 * WORDS + 2;
`else
  localparam int N_CHARS = 4 * WORDS;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        done = 1'b0;
  logic        tx_ready = 1'b1;
  logic [15:0] result [0:WORDS-1];
  logic        busy, tx_valid, stream_done;
  logic [7:0]  tx_data;

  int   n_vec = 0;
  int   n_miss = 0;
  int   sd_count = 0;
  int   cyc = 0;
  int   sd_before;
  bit   toggle_mode = 1'b0;
  logic [3:0] ready_pat = 4'b1001;
  logic [7:0] exp_q [$];
  logic       stall_pend = 1'b0;
  logic [7:0] stall_val = 8'h00;

  // "2b7e1516" for result[1] = 2b7e, result[0] = 1516
  logic [7:0] golden [0:7] = '{8'h32, 8'h62, 8'h37, 8'h65, 8'h31, 8'h35, 8'h31, 8'h36};

  e_result_streamer #(.WORDS(WORDS)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .done        (done),
    .result      (result),
    .busy        (busy),
    .tx_valid    (tx_valid),
    .tx_data     (tx_data),
    .tx_ready    (tx_ready),
    .stream_done (stream_done)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    if (toggle_mode) tx_ready = ready_pat[cyc[1:0]];
  endtask

  task automatic push_stream();
    for (int i = 0; i < 8; i++) exp_q.push_back(golden[i]);
`ifdef E_STREAM_EOL_EN
    exp_q.push_back(8'h0D);
    exp_q.push_back(8'h0A);
`endif
  endtask

  task automatic wait_stream_end(input string name, input int max);
    int n = 0;
    while (!stream_done && n < max) begin
      tick();
      n++;
    end
    check({name, "_stream_done"}, {31'd0, stream_done}, 32'd1);
    tick();
  endtask

  // Monitor: compares every accepted character against the scoreboard and
  // confirms stalled characters are held.
  always @(negedge clk) begin
    if (!rst_n) begin
      stall_pend = 1'b0;
    end else begin
      if (stall_pend) begin
        check("stall_valid", {31'd0, tx_valid}, 32'd1);
        check("stall_data", {24'd0, tx_data}, {24'd0, stall_val});
      end
      if (tx_valid && tx_ready) begin
        if (exp_q.size() == 0) begin
          n_vec++;
          n_miss++;
          $display("FAIL extra_char: got %h, expected no character (t=%0t)", tx_data, $time);
        end else begin
          check("char", {24'd0, tx_data}, {24'd0, exp_q.pop_front()});
        end
      end
      stall_pend = tx_valid && !tx_ready;
      stall_val  = tx_data;
      if (stream_done) sd_count++;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    result[1] = 16'h2b7e;
    result[0] = 16'h1516;

    // Reset state
    #2;
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_valid", {31'd0, tx_valid}, 32'd0);
    check("rst_data", {24'd0, tx_data}, 32'h00);
    check("rst_stream_done", {31'd0, stream_done}, 32'd0);
    tick();
    rst_n = 1'b1;
    tick();
    tick();

    // 1: ready tied high, exact cycle timing
    sd_before = sd_count;
    push_stream();
    done = 1'b1;
    tick();
    done = 1'b0;
    check("t1_busy_after_capture", {31'd0, busy}, 32'd1);
    check("t1_valid_after_capture", {31'd0, tx_valid}, 32'd1);
    check("t1_first_char", {24'd0, tx_data}, 32'h32);
    for (int i = 1; i < N_CHARS; i++) tick();
    check("t1_valid_last", {31'd0, tx_valid}, 32'd1);
    check("t1_no_early_done", {31'd0, stream_done}, 32'd0);
    tick();
    check("t1_stream_done", {31'd0, stream_done}, 32'd1);
    check("t1_busy_fin", {31'd0, busy}, 32'd0);
    check("t1_valid_fin", {31'd0, tx_valid}, 32'd0);
    tick();
    check("t1_done_one_cycle", {31'd0, stream_done}, 32'd0);
    check("t1_queue_empty", exp_q.size(), 32'd0);
    check("t1_pulse_count", sd_count - sd_before, 32'd1);

    // 2: tx_ready toggling 1-0-0-1
    sd_before = sd_count;
    push_stream();
    toggle_mode = 1'b1;
    done = 1'b1;
    tick();
    done = 1'b0;
    wait_stream_end("t2", 200);
    toggle_mode = 1'b0;
    tx_ready = 1'b1;
    check("t2_queue_empty", exp_q.size(), 32'd0);
    check("t2_pulse_count", sd_count - sd_before, 32'd1);

    // 3: result changes mid-stream; snapshot must win
    push_stream();
    done = 1'b1;
    tick();
    done = 1'b0;
    tick();
    tick();
    result[1] = 16'hffff;
    result[0] = 16'hffff;
    wait_stream_end("t3", 100);
    check("t3_queue_empty", exp_q.size(), 32'd0);
    result[1] = 16'h2b7e;
    result[0] = 16'h1516;

    // 4: second rise while busy is ignored; held done never retriggers
    sd_before = sd_count;
    push_stream();
    done = 1'b1;
    tick();
    done = 1'b0;
    tick();
    done = 1'b1;
    wait_stream_end("t4", 100);
    for (int i = 0; i < 20; i++) tick();
    check("t4_pulse_count", sd_count - sd_before, 32'd1);
    check("t4_idle_busy", {31'd0, busy}, 32'd0);
    check("t4_queue_empty", exp_q.size(), 32'd0);
    done = 1'b0;
    tick();

    // 5: done high through reset release does not trigger
    done = 1'b1;
    tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) tick();
    check("t5_no_trigger_busy", {31'd0, busy}, 32'd0);
    check("t5_no_trigger_valid", {31'd0, tx_valid}, 32'd0);
    done = 1'b0;
    tick();
    push_stream();
    done = 1'b1;
    tick();
    done = 1'b0;
    check("t5_new_rise_busy", {31'd0, busy}, 32'd1);
    wait_stream_end("t5", 100);
    check("t5_queue_empty", exp_q.size(), 32'd0);

    // 6: reset at the third character aborts at once
    sd_before = sd_count;
    exp_q.push_back(golden[0]);
    exp_q.push_back(golden[1]);
    done = 1'b1;
    tick();
    done = 1'b0;
    tick();
    tick();
    check("t6_third_char", {24'd0, tx_data}, {24'd0, golden[2]});
    rst_n = 1'b0;
    #1;
    check("t6_abort_valid", {31'd0, tx_valid}, 32'd0);
    check("t6_abort_busy", {31'd0, busy}, 32'd0);
    check("t6_abort_stream_done", {31'd0, stream_done}, 32'd0);
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) tick();
    check("t6_quiet_busy", {31'd0, busy}, 32'd0);
    check("t6_partial_consumed", exp_q.size(), 32'd0);
    check("t6_no_pulse", sd_count - sd_before, 32'd0);
    push_stream();
    done = 1'b1;
    tick();
    done = 1'b0;
    wait_stream_end("t6_restart", 100);
    check("t6_restart_queue_empty", exp_q.size(), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
